dma_burst_engine: RTL and testbench

- Single-channel AXI master that copies `cfg_len` 32-bit words from `cfg_src` to `cfg_dst`.
- It sits on the bus directly upstream of the DRAM slave wrapper, which serves its AR/R/AW/W/B traffic.
- Transfers are split into INCR bursts of at most 16 beats. No burst crosses a 4 KB (DRAM row) boundary, so the wrapper never row-overflows mid-burst.
- Data goes through a 16-entry internal buffer: each chunk is one read burst followed by one write burst.

---
 rtl/dma_burst_engine.sv | 214 +++++++++++++++++++++
 tb/tb_dma_burst_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_engine.sv
// Single-channel AXI copy engine: moves cfg_len words from cfg_src to cfg_dst through a
// 16-word buffer, one read burst then one write burst per chunk, never crossing a 4 KB row.
module dma_burst_engine #(
    parameter logic [3:0] MID       = 4'd2,
    parameter int         MAX_BEATS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cfg_src,
    input  logic [31:0] cfg_dst,
    input  logic [15:0] cfg_len,
    input  logic        cfg_start,
    input  logic        cfg_clr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic [3:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY
);
    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_AR, S_R, S_AW, S_W, S_B, S_DONE
    } state_t;

    localparam logic [15:0] MAX_BEATS_W = 16'(MAX_BEATS);

    state_t      state_reg, state_next;
    logic [31:0] src_ptr_reg, dst_ptr_reg;
    logic [15:0] remain_reg;
    logic [3:0]  blen_reg, rcnt_reg, wcnt_reg;
    logic [31:0] wdata_reg;
    logic        done_reg, err_reg;
    logic [31:0] buf_mem [0:15];

    logic [10:0] src_room, dst_room;
    logic [15:0] calc_beats;
    logic [4:0]  beats;
    logic [15:0] remain_after;
    logic        r_hs, r_end, aw_hs, w_hs, w_end, b_hs;
    logic        unused_ok;

    // IDs are not checked and the low address bits are forced to zero.
    assign unused_ok = ^{RID, BID, cfg_src[1:0], cfg_dst[1:0]};

    // Words left before the next 4 KB row boundary (1..1024).
    assign src_room = 11'd1024 - {1'b0, src_ptr_reg[11:2]};
    assign dst_room = 11'd1024 - {1'b0, dst_ptr_reg[11:2]};

    always_comb begin
        calc_beats = remain_reg;
        if (calc_beats > MAX_BEATS_W)
            calc_beats = MAX_BEATS_W;
        if ({5'd0, src_room} < calc_beats)
            calc_beats = {5'd0, src_room};
        if ({5'd0, dst_room} < calc_beats)
            calc_beats = {5'd0, dst_room};
    end

    assign beats        = {1'b0, blen_reg} + 5'd1;
    assign remain_after = remain_reg - {11'd0, beats};

    assign r_hs  = (state_reg == S_R) && RVALID;
    assign r_end = r_hs && (RLAST || (rcnt_reg == blen_reg));
    assign aw_hs = (state_reg == S_AW) && AWREADY;
    assign w_hs  = (state_reg == S_W) && WREADY;
    assign w_end = w_hs && (wcnt_reg == blen_reg);
    assign b_hs  = (state_reg == S_B) && BVALID;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        ARVALID    = 1'b0;
        RREADY     = 1'b0;
        AWVALID    = 1'b0;
        WVALID     = 1'b0;
        BREADY     = 1'b0;
        case (state_reg)
            S_IDLE: if (cfg_start) state_next = (cfg_len == 16'd0) ? S_DONE : S_CALC;
            S_CALC: state_next = S_AR;
            S_AR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_next = S_R;
            end
            S_R: begin
                RREADY = 1'b1;
                if (r_end) state_next = S_AW;
            end
            S_AW: begin
                AWVALID = 1'b1;
                if (AWREADY) state_next = S_W;
            end
            S_W: begin
                WVALID = 1'b1;
                if (w_end) state_next = S_B;
            end
            S_B: begin
                BREADY = 1'b1;
                if (BVALID) state_next = (remain_after == 16'd0) ? S_DONE : S_CALC;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Buffer write port: one word per accepted read beat.
    always_ff @(posedge clk) begin
        if (r_hs)
            buf_mem[rcnt_reg] <= RDATA;
    end

    // Datapath; the buffer read is registered and prefetched one beat ahead of WDATA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_ptr_reg <= 32'd0;
            dst_ptr_reg <= 32'd0;
            remain_reg  <= 16'd0;
            blen_reg    <= 4'd0;
            rcnt_reg    <= 4'd0;
            wcnt_reg    <= 4'd0;
            wdata_reg   <= 32'd0;
        end else begin
            case (state_reg)
                S_IDLE: if (cfg_start) begin
                    src_ptr_reg <= {cfg_src[31:2], 2'b00};
                    dst_ptr_reg <= {cfg_dst[31:2], 2'b00};
                    remain_reg  <= cfg_len;
                end
                S_CALC: blen_reg <= 4'(calc_beats - 16'd1);
                S_R: if (r_hs) rcnt_reg <= r_end ? 4'd0 : rcnt_reg + 4'd1;
                S_AW: if (aw_hs) wdata_reg <= buf_mem[4'd0];
                S_W: if (w_hs) begin
                    wcnt_reg <= w_end ? 4'd0 : wcnt_reg + 4'd1;
                    if (!w_end)
                        wdata_reg <= buf_mem[wcnt_reg + 4'd1];
                end
                S_B: if (b_hs) begin
                    src_ptr_reg <= src_ptr_reg + {25'd0, beats, 2'b00};
                    dst_ptr_reg <= dst_ptr_reg + {25'd0, beats, 2'b00};
                    remain_reg  <= remain_after;
                end
                default: ;
            endcase
        end
    end

    // Sticky flags; a clear wins over a set in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            if (cfg_clr)
                done_reg <= 1'b0;
            else if (state_reg == S_DONE)
                done_reg <= 1'b1;
            if (cfg_clr)
                err_reg <= 1'b0;
            else if ((r_hs && RRESP != 2'b00) || (b_hs && BRESP != 2'b00))
                err_reg <= 1'b1;
        end
    end

    assign busy    = (state_reg != S_IDLE);
    assign done    = done_reg;
    assign err     = err_reg;

    assign ARID    = ARVALID ? MID : 4'd0;
    assign ARADDR  = src_ptr_reg;
    assign ARLEN   = blen_reg;
    assign ARSIZE  = ARVALID ? 3'b010 : 3'b000;
    assign ARBURST = ARVALID ? 2'b01 : 2'b00;

    assign AWID    = AWVALID ? MID : 4'd0;
    assign AWADDR  = dst_ptr_reg;
    assign AWLEN   = blen_reg;
    assign AWSIZE  = AWVALID ? 3'b010 : 3'b000;
    assign AWBURST = AWVALID ? 2'b01 : 2'b00;

    assign WDATA   = wdata_reg;
    assign WSTRB   = WVALID ? 4'hF : 4'h0;
    assign WLAST   = WVALID && (wcnt_reg == blen_reg);
endmodule

// File: tb/tb_dma_burst_engine.sv
// Bench for dma_burst_engine: randomized-latency AXI slave plus a burst/data reference
// model derived from the 4 KB / 16-beat splitting rules.
`timescale 1ns/1ps
module tb_dma_burst_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_src = 32'd0, cfg_dst = 32'd0;
    logic [15:0] cfg_len = 16'd0;
    logic        cfg_start = 1'b0, cfg_clr = 1'b0;
    logic        busy, done, err;
    logic [3:0]  ARID, ARLEN, AWID, AWLEN, WSTRB;
    logic [31:0] ARADDR, AWADDR, WDATA;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST;
    logic        ARVALID, RREADY, AWVALID, WLAST, WVALID, BREADY;
    logic        ARREADY = 1'b0, RLAST = 1'b0, RVALID = 1'b0, AWREADY = 1'b0;
    logic        WREADY = 1'b0, BVALID = 1'b0;
    logic [3:0]  RID = 4'd2, BID = 4'd2;
    logic [31:0] RDATA = 32'd0;
    logic [1:0]  RRESP = 2'b00, BRESP = 2'b00;

    always #5 clk = ~clk;

    dma_burst_engine #(.MID(4'd2), .MAX_BEATS(16)) dut (
        .clk(clk), .rst(rst), .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
        .cfg_start(cfg_start), .cfg_clr(cfg_clr), .busy(busy), .done(done), .err(err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
        .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .AWID(AWID), .AWADDR(AWADDR),
        .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWVALID(AWVALID),
        .AWREADY(AWREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY), .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    typedef struct { logic [31:0] addr; logic [3:0] len; logic [8:0] attr; } addr_rec_t;
    typedef struct { logic [31:0] src; logic [31:0] dst; logic [3:0] len; } burst_t;

    int vectors = 0;
    int miscompares = 0;
    int max_dly = 0;
    int inj_rbeat = -1;
    int rbeat_total = 0;
    addr_rec_t ar_log[$], aw_log[$], aw_pend[$], r_pend[$];
    burst_t exp_q[$];
    logic [31:0] wmem [logic [31:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] srcword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic int rnd_dly();
        return int'($urandom_range(32'(max_dly), 0));
    endfunction

    // Reference burst list: each chunk is bounded by what is left, 16 beats and both rows.
    function automatic void build_model(input logic [31:0] s, input logic [31:0] d, input int n);
        int left, rs, rd, b;
        left = n;
        exp_q.delete();
        while (left > 0) begin
            rs = (4096 - int'(s[11:0])) / 4;
            rd = (4096 - int'(d[11:0])) / 4;
            b = (left > 16) ? 16 : left;
            if (rs < b) b = rs;
            if (rd < b) b = rd;
            exp_q.push_back('{s, d, 4'(b - 1)});
            s = s + 32'(4 * b);
            d = d + 32'(4 * b);
            left = left - b;
        end
    endfunction

    // ---------------- AXI slave: AR ----------------
    int ar_wait; bit ar_seen = 0, ar_hs = 0; logic [35:0] ar_hold;
    always @(negedge clk) begin
        if (rst) begin
            ARREADY = 1'b0; ar_seen = 0; ar_hs = 0; r_pend.delete();
        end else begin
            if (ar_hs) begin ar_hs = 0; ar_seen = 0; ARREADY = 1'b0; end
            if (ARVALID) begin
                if (!ar_seen) begin
                    ar_seen = 1; ar_wait = rnd_dly(); ar_hold = {ARADDR, ARLEN};
                end else
                    check("ar_stable", 64'({ARADDR, ARLEN}), 64'(ar_hold));
                if (ar_wait == 0) begin
                    ARREADY = 1'b1; ar_hs = 1;
                    ar_log.push_back('{ARADDR, ARLEN, {ARID, ARSIZE, ARBURST}});
                    r_pend.push_back('{ARADDR, ARLEN, 9'd0});
                end else begin
                    ARREADY = 1'b0; ar_wait--;
                end
            end else
                ARREADY = 1'b0;
        end
    end

    // ---------------- AXI slave: R ----------------
    int r_wait, r_beat; bit r_active = 0, r_hs = 0; addr_rec_t r_cur;
    always @(negedge clk) begin
        if (rst) begin
            RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; r_active = 0; r_hs = 0;
        end else begin
            if (r_hs) begin
                r_hs = 0; RVALID = 1'b0; r_beat++; rbeat_total++;
                if (r_beat > int'(r_cur.len)) r_active = 0;
                r_wait = rnd_dly();
            end
            if (!r_active && r_pend.size() > 0) begin
                r_cur = r_pend.pop_front(); r_active = 1; r_beat = 0; r_wait = rnd_dly();
            end
            if (r_active) begin
                if (!RVALID) begin
                    if (r_wait == 0) begin
                        RVALID = 1'b1;
                        RDATA  = srcword(r_cur.addr + 32'(4 * r_beat));
                        RLAST  = (r_beat == int'(r_cur.len));
                        RRESP  = (rbeat_total == inj_rbeat) ? 2'b10 : 2'b00;
                    end else
                        r_wait--;
                end
                if (RVALID && RREADY) r_hs = 1;
            end
        end
    end

    // ---------------- AXI slave: AW ----------------
    int aw_wait; bit aw_seen = 0, aw_hs = 0; logic [35:0] aw_hold;
    always @(negedge clk) begin
        if (rst) begin
            AWREADY = 1'b0; aw_seen = 0; aw_hs = 0; aw_pend.delete();
        end else begin
            if (aw_hs) begin aw_hs = 0; aw_seen = 0; AWREADY = 1'b0; end
            if (AWVALID) begin
                if (!aw_seen) begin
                    aw_seen = 1; aw_wait = rnd_dly(); aw_hold = {AWADDR, AWLEN};
                end else
                    check("aw_stable", 64'({AWADDR, AWLEN}), 64'(aw_hold));
                if (aw_wait == 0) begin
                    AWREADY = 1'b1; aw_hs = 1;
                    aw_log.push_back('{AWADDR, AWLEN, {AWID, AWSIZE, AWBURST}});
                    aw_pend.push_back('{AWADDR, AWLEN, 9'd0});
                end else begin
                    AWREADY = 1'b0; aw_wait--;
                end
            end else
                AWREADY = 1'b0;
        end
    end

    // ---------------- AXI slave: W and B ----------------
    int w_wait, w_beat = 0, b_pend = 0, b_wait;
    bit w_seen = 0, w_hs = 0, b_hs = 0, b_active = 0;
    logic [36:0] w_hold;
    always @(negedge clk) begin
        if (rst) begin
            WREADY = 1'b0; w_seen = 0; w_hs = 0; w_beat = 0;
        end else begin
            if (w_hs) begin w_hs = 0; w_seen = 0; WREADY = 1'b0; end
            if (WVALID) begin
                if (!w_seen) begin
                    w_seen = 1; w_wait = rnd_dly(); w_hold = {WSTRB, WLAST, WDATA};
                    check("w_after_aw", 64'({AWVALID, aw_pend.size() > 0}), 64'd1);
                end else
                    check("w_stable", 64'({WSTRB, WLAST, WDATA}), 64'(w_hold));
                if (w_wait == 0 && aw_pend.size() > 0) begin
                    WREADY = 1'b1; w_hs = 1;
                    wmem[aw_pend[0].addr + 32'(4 * w_beat)] = WDATA;
                    check("wlast", 64'({WSTRB, WLAST}), 64'({4'hF, w_beat == int'(aw_pend[0].len)}));
                    w_beat++;
                    if (WLAST) begin
                        void'(aw_pend.pop_front()); w_beat = 0; b_pend++;
                    end
                end else begin
                    WREADY = 1'b0;
                    if (w_wait > 0) w_wait--;
                end
            end else
                WREADY = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            BVALID = 1'b0; BRESP = 2'b00; b_pend = 0; b_hs = 0; b_active = 0;
        end else begin
            if (b_hs) begin b_hs = 0; BVALID = 1'b0; b_pend--; b_active = 0; end
            if (!b_active && b_pend > 0) begin b_active = 1; b_wait = rnd_dly(); end
            if (b_active && !BVALID) begin
                if (b_wait == 0) begin BVALID = 1'b1; BRESP = 2'b00; end
                else b_wait--;
            end
            if (BVALID && BREADY) b_hs = 1;
        end
    end

    // ---------------- directed copy with full checking ----------------
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input bit exp_err, input bit restart_mid);
        int cyc;
        logic [31:0] a;
        cfg_clr = 1'b1;
        @(negedge clk);
        cfg_clr = 1'b0;
        check("clr_flags", 64'({done, err}), 64'd0);
        ar_log.delete(); aw_log.delete(); wmem.delete(); rbeat_total = 0;
        cfg_src = s; cfg_dst = d; cfg_len = n; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("busy_rise", 64'(busy), 64'd1);
        if (restart_mid) begin
            repeat (8) @(negedge clk);
            cfg_src = s ^ 32'h0001_0000; cfg_dst = d ^ 32'h0002_0000; cfg_len = 16'd3;
            cfg_start = 1'b1;
            @(negedge clk);
            cfg_start = 1'b0;
        end
        for (cyc = 0; cyc < 4000 && done !== 1'b1; cyc++) @(negedge clk);
        check("done_set", 64'({done, busy}), 64'b10);
        check("err_flag", 64'(err), 64'(exp_err));
        build_model(s, d, int'(n));
        check("ar_count", 64'(ar_log.size()), 64'(exp_q.size()));
        check("aw_count", 64'(aw_log.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < ar_log.size()) begin
                check("araddr", 64'(ar_log[i].addr), 64'(exp_q[i].src));
                check("arlen", 64'({ar_log[i].len, ar_log[i].attr}), 64'({exp_q[i].len, 9'b0010_010_01}));
            end
            if (i < aw_log.size()) begin
                check("awaddr", 64'(aw_log[i].addr), 64'(exp_q[i].dst));
                check("awlen", 64'({aw_log[i].len, aw_log[i].attr}), 64'({exp_q[i].len, 9'b0010_010_01}));
            end
        end
        for (int i = 0; i < int'(n); i++) begin
            a = d + 32'(4 * i);
            check("wdata", 64'(wmem.exists(a) ? wmem[a] : 32'hxxxx_xxxx), 64'(srcword(s + 32'(4 * i))));
        end
        repeat (4) @(negedge clk);
        check("no_extra", 64'({busy, 8'(ar_log.size())}), 64'({1'b0, 8'(exp_q.size())}));
        $display("copy src=%h dst=%h len=%0d bursts=%0d err=%0b cycles=%0d",
                 s, d, n, exp_q.size(), err, cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit found;
        logic [31:0] rs, rd;
        logic [15:0] rl;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({busy, done, err, ARVALID, RREADY, AWVALID, WVALID, BREADY}), 64'd0);
        check("rst_addr", 64'({ARADDR, AWADDR}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Aligned single burst, zero-wait slave.
        max_dly = 0;
        run_copy(32'h2000_0000, 32'h2000_1000, 16'd16, 1'b0, 1'b0);
        // Source crosses a 4 KB row: 4 + 6 beats.
        run_copy(32'h2000_0FF0, 32'h2000_2000, 16'd10, 1'b0, 1'b0);
        // Long copy under backpressure: 16, 16, 8.
        max_dly = 5;
        run_copy(32'h3000_0000, 32'h3000_8000, 16'd40, 1'b0, 1'b0);
        // Randomized addresses and lengths.
        for (int k = 0; k < 4; k++) begin
            rs = $urandom & 32'hFFFF_FFFC;
            rd = $urandom & 32'hFFFF_FFFC;
            rl = 16'($urandom_range(60, 1));
            run_copy(rs, rd, rl, 1'b0, 1'b0);
        end
        // Second start while busy is ignored.
        run_copy(32'h4000_0000, 32'h4000_0800, 16'd20, 1'b0, 1'b1);

        // Read error on one beat: copy completes, err sticky.
        max_dly = 1;
        inj_rbeat = 3;
        run_copy(32'h6000_0000, 32'h6000_1000, 16'd8, 1'b1, 1'b0);
        inj_rbeat = -1;
        // A new start (zero length) clears neither flag.
        cfg_len = 16'd0; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        @(negedge clk);
        check("flags_kept", 64'({done, err}), 64'b11);
        cfg_clr = 1'b1;
        @(negedge clk);
        cfg_clr = 1'b0;
        check("clr_both", 64'({done, err}), 64'd0);

        // Zero length: one-cycle busy pulse, done on the second edge, no bus traffic.
        ar_log.delete(); aw_log.delete();
        cfg_len = 16'd0; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("zl_busy", 64'({busy, done}), 64'b10);
        @(negedge clk);
        check("zl_done", 64'({busy, done}), 64'b01);
        repeat (3) @(negedge clk);
        check("zl_nobus", 64'(ar_log.size() + aw_log.size()), 64'd0);
        $display("copy zero-length done=%0b", done);

        // Asynchronous reset in the middle of a write burst.
        max_dly = 2;
        cfg_src = 32'h7000_0000; cfg_dst = 32'h7000_4000; cfg_len = 16'd16; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        found = 0;
        for (cyc = 0; cyc < 2000 && !found; cyc++) begin
            @(negedge clk);
            found = WVALID;
        end
        check("wvalid_seen", 64'(found), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ctrl", 64'({busy, done, err, ARVALID, RREADY, AWVALID, WVALID, BREADY, WLAST}), 64'd0);
        check("mid_rst_addr", 64'({ARADDR, AWADDR}), 64'd0);
        check("mid_rst_misc", 64'({WDATA, ARLEN, AWLEN, ARSIZE, AWSIZE, ARBURST, AWBURST, WSTRB, ARID, AWID}), 64'd0);
        $display("reset during write burst busy=%0b wvalid=%0b", busy, WVALID);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Recovery copy where both rows are nearly exhausted: 1, 1, 4 beats.
        run_copy(32'h5000_0FF8, 32'h5000_3FFC, 16'd6, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
